// File: rtl/xpsr_it_ctrl.sv
// IT-block sequencer and xPSR write-enable gate.
// Tracks ITSTATE ({cond, mask}) across an IT block, evaluates each
// instruction's condition against the APSR flags and gates flag writes.
module xpsr_it_ctrl #(
  parameter int INST_W      = 32,
  parameter int IT_W        = 8,
  parameter bit NEST_ERR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] inst,
  input  logic              inst_valid,
  input  logic              flush,
  input  logic [4:0]        apsr,
  input  logic              apsr_wr_req,
  input  logic              carry_wr_req,
  input  logic              exc_entry,
  input  logic              exc_return,
  input  logic [IT_W-1:0]   it_restore,
  output logic [IT_W-1:0]   epsr_it,
  output logic              en_epsr,
  output logic              en_apsr,
  output logic              en_carry,
  output logic              cond_pass,
  output logic              in_it,
  output logic              last_in_it,
  output logic              it_err
);

  typedef enum logic {IDLE, IT_ACTIVE} state_t;

  state_t            state_reg, state_next;
  logic [IT_W-1:0]   it_reg, it_next;
  logic              en_epsr_reg, en_epsr_next;
  logic              it_err_reg, it_err_next;

  logic              retire;
  logic              is_it;
  logic [3:0]        cond;
  logic              flag_n, flag_z, flag_c, flag_v;
  logic [IT_W-1:0]   it_load;

  assign retire = inst_valid & ~flush;
  // Mask of zero encodes a hint (NOP-compatible), not an IT.
  assign is_it  = (inst[15:8] == 8'hBF) && (inst[3:0] != 4'h0);
  assign it_load = {inst[7:4], inst[3:0]};

  assign flag_n = apsr[4];
  assign flag_z = apsr[3];
  assign flag_c = apsr[2];
  assign flag_v = apsr[1];

  assign in_it      = (state_reg == IT_ACTIVE);
  assign last_in_it = in_it && (it_reg[2:0] == 3'b000);
  assign cond       = in_it ? it_reg[7:4] : 4'hE;

  // Standard ARM condition evaluation; 0xE and 0xF both always execute.
  always_comb begin
    cond_pass = 1'b1;
    case (cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = ~flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = ~flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = ~flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = ~flag_v;
      4'h8: cond_pass = flag_c & ~flag_z;
      4'h9: cond_pass = ~flag_c | flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = ~flag_z & (flag_n == flag_v);
      4'hD: cond_pass = flag_z | (flag_n != flag_v);
      default: cond_pass = 1'b1;
    endcase
  end

  assign en_apsr  = apsr_wr_req  & cond_pass & retire;
  assign en_carry = carry_wr_req & cond_pass & retire;

  // Next ITSTATE / state: exception entry beats return beats retire.
  always_comb begin
    state_next   = state_reg;
    it_next      = it_reg;
    en_epsr_next = 1'b0;
    it_err_next  = 1'b0;
    if (exc_entry) begin
      it_next      = '0;
      state_next   = IDLE;
      en_epsr_next = 1'b1;
    end else if (exc_return) begin
      it_next      = it_restore;
      state_next   = (it_restore[3:0] != 4'h0) ? IT_ACTIVE : IDLE;
      en_epsr_next = 1'b1;
    end else if (retire) begin
      case (state_reg)
        IDLE: begin
          if (is_it) begin
            it_next    = it_load;
            state_next = IT_ACTIVE;
          end
        end
        IT_ACTIVE: begin
          if (it_reg[2:0] == 3'b000) begin
            // Last slot: block ends; an IT here starts a fresh block at once.
            if (is_it) begin
              it_next    = it_load;
              state_next = IT_ACTIVE;
            end else begin
              it_next    = '0;
              state_next = IDLE;
            end
          end else begin
            // Shift the mask; the base condition bits [7:5] stay put.
            it_next     = {it_reg[7:5], it_reg[3:0], 1'b0};
            it_err_next = NEST_ERR_EN && is_it;
          end
        end
        default: begin
          it_next    = '0;
          state_next = IDLE;
        end
      endcase
      en_epsr_next = (it_next != it_reg);
    end
  end

  // State, ITSTATE and registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      it_reg      <= '0;
      en_epsr_reg <= 1'b0;
      it_err_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      it_reg      <= it_next;
      en_epsr_reg <= en_epsr_next;
      it_err_reg  <= it_err_next;
    end
  end

  assign epsr_it = it_reg;
  assign en_epsr = en_epsr_reg;
  assign it_err  = it_err_reg;

endmodule

// File: tb/tb_xpsr_it_ctrl.sv
// Directed self-checking bench for xpsr_it_ctrl.
module tb_xpsr_it_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        inst_valid, flush;
  logic [4:0]  apsr;
  logic        apsr_wr_req, carry_wr_req;
  logic        exc_entry, exc_return;
  logic [7:0]  it_restore;
  logic [7:0]  epsr_it;
  logic        en_epsr, en_apsr, en_carry, cond_pass, in_it, last_in_it, it_err;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_Z    = 5'b01000;
  localparam logic [4:0] F_N    = 5'b10000;
  localparam logic [4:0] F_NV   = 5'b10010;

  xpsr_it_ctrl dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .flush(flush),
    .apsr(apsr), .apsr_wr_req(apsr_wr_req), .carry_wr_req(carry_wr_req),
    .exc_entry(exc_entry), .exc_return(exc_return), .it_restore(it_restore),
    .epsr_it(epsr_it), .en_epsr(en_epsr), .en_apsr(en_apsr), .en_carry(en_carry),
    .cond_pass(cond_pass), .in_it(in_it), .last_in_it(last_in_it), .it_err(it_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic [4:0] f,
                       input logic awr, input logic cwr);
    @(negedge clk);
    inst = i; inst_valid = v; apsr = f; apsr_wr_req = awr; carry_wr_req = cwr;
    #1;
  endtask

  initial begin
    rst = 1'b0; inst = '0; inst_valid = 0; flush = 0; apsr = '0;
    apsr_wr_req = 0; carry_wr_req = 0; exc_entry = 0; exc_return = 0; it_restore = '0;
    #3;
    check("reset_epsr_it", epsr_it, 8'h00);
    check("reset_en_epsr", en_epsr, 0);
    check("reset_it_err", it_err, 0);
    check("reset_in_it", in_it, 0);
    @(negedge clk); rst = 1'b1;

    // IT EQ, Z=1
    drive(32'h0000BF08, 1, F_Z, 0, 0);
    check("it_eq_cond_pass", cond_pass, 1);
    tick();
    check("it_eq_load", epsr_it, 8'h08);
    check("it_eq_en_epsr", en_epsr, 1);
    check("it_eq_in_it", in_it, 1);
    check("it_eq_last", last_in_it, 1);
    drive(32'h0, 1, F_Z, 1, 0);
    check("it_eq_slot_pass", cond_pass, 1);
    check("it_eq_slot_en_apsr", en_apsr, 1);
    tick();
    check("it_eq_done", epsr_it, 8'h00);
    check("it_eq_idle", in_it, 0);
    drive(32'h0, 0, F_Z, 0, 0);
    tick();
    check("quiet_en_epsr", en_epsr, 0);

    // ITTE NE, Z=0
    drive(32'h0000BF1A, 1, F_NONE, 0, 0);
    tick();
    check("itte_load", epsr_it, 8'h1A);
    drive(32'h0, 1, F_NONE, 1, 0);
    check("itte_s1_pass", cond_pass, 1);
    check("itte_s1_en_apsr", en_apsr, 1);
    tick();
    check("itte_s1_adv", epsr_it, 8'h14);
    drive(32'h0, 1, F_NONE, 1, 0);
    check("itte_s2_pass", cond_pass, 1);
    tick();
    check("itte_s2_adv", epsr_it, 8'h08);
    drive(32'h0, 1, F_NONE, 1, 0);
    check("itte_s3_pass", cond_pass, 0);
    check("itte_s3_en_apsr", en_apsr, 0);
    tick();
    check("itte_s3_adv", epsr_it, 8'h00);
    check("itte_idle", in_it, 0);

    // exception entry with a retiring instruction, then return
    drive(32'h0000BF1A, 1, F_NONE, 0, 0);
    tick();
    drive(32'h0, 1, F_NONE, 0, 0);
    tick();
    check("exc_pre", epsr_it, 8'h14);
    drive(32'h0, 1, F_NONE, 0, 0);
    exc_entry = 1;
    tick();
    check("exc_entry_it", epsr_it, 8'h00);
    check("exc_entry_en", en_epsr, 1);
    check("exc_entry_in_it", in_it, 0);
    drive(32'h0, 0, F_NONE, 0, 0);
    exc_entry = 0; exc_return = 1; it_restore = 8'h14;
    tick();
    check("exc_ret_it", epsr_it, 8'h14);
    check("exc_ret_in_it", in_it, 1);
    check("exc_ret_en", en_epsr, 1);
    exc_return = 0;

    // flush during a slot: hold and no enables
    drive(32'h0, 1, F_NONE, 1, 1);
    flush = 1;
    #1;
    check("flush_en_apsr", en_apsr, 0);
    check("flush_en_carry", en_carry, 0);
    tick();
    check("flush_hold", epsr_it, 8'h14);
    check("flush_en_epsr", en_epsr, 0);
    flush = 0;

    // carry-only write in slot (NE, Z=0)
    drive(32'h0, 1, F_NONE, 0, 1);
    check("carry_en", en_carry, 1);
    tick();
    check("carry_adv", epsr_it, 8'h08);
    // IT in the last slot starts a new block, no error
    drive(32'h0000BF08, 1, F_NONE, 0, 0);
    check("last_eq_fail", cond_pass, 0);
    tick();
    check("last_nest_load", epsr_it, 8'h08);
    check("last_nest_in_it", in_it, 1);
    check("last_nest_no_err", it_err, 0);
    drive(32'h0, 1, F_NONE, 0, 0);
    tick();
    check("last_nest_done", epsr_it, 8'h00);

    // nested IT not in last slot
    drive(32'h0000BF1A, 1, F_NONE, 0, 0);
    tick();
    drive(32'h0000BF08, 1, F_NONE, 0, 0);
    tick();
    check("nest_err", it_err, 1);
    check("nest_adv", epsr_it, 8'h14);
    drive(32'h0, 0, F_NONE, 0, 0);
    tick();
    check("nest_err_clear", it_err, 0);
    exc_entry = 1;
    tick();
    exc_entry = 0;
    check("nest_cleanup", epsr_it, 8'h00);

    // ITT GE: N=1,V=0 fails; N=1,V=1 passes
    drive(32'h0000BFA4, 1, F_NONE, 0, 0);
    tick();
    check("ge_load", epsr_it, 8'hA4);
    drive(32'h0, 1, F_N, 0, 0);
    check("ge_fail", cond_pass, 0);
    tick();
    check("ge_adv", epsr_it, 8'hA8);
    drive(32'h0, 1, F_NV, 0, 0);
    check("ge_pass", cond_pass, 1);
    tick();
    check("ge_done", epsr_it, 8'h00);

    // hint in IDLE
    drive(32'h0000BF00, 1, F_NONE, 0, 0);
    tick();
    check("hint_it", epsr_it, 8'h00);
    check("hint_en_epsr", en_epsr, 0);
    check("hint_in_it", in_it, 0);

    // async reset mid-block
    drive(32'h0000BF1A, 1, F_NONE, 0, 0);
    tick();
    drive(32'h0, 1, F_NONE, 0, 0);
    tick();
    check("rst_pre", epsr_it, 8'h14);
    @(negedge clk);
    inst_valid = 0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_it", epsr_it, 8'h00);
    check("async_rst_in_it", in_it, 0);
    @(negedge clk); rst = 1'b1;
    drive(32'h0, 1, F_Z, 1, 0);
    check("post_rst_pass", cond_pass, 1);
    tick();
    drive(32'h0, 0, F_NONE, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
